// File: rtl/popcount_pkg.sv
// Shared types and helpers for the streaming popcount block.
//   cnt_w(width) : bit width needed to hold a count of 0..width
//   state_e      : FSM states of popcount_stream
package popcount_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COUNT = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one CHUNK-bit slice.
// Ports:
//   data  : CHUNK-bit slice to count
//   count : number of ones in data, cnt_w(CHUNK) bits wide
module popcount_chunk
   import popcount_pkg::*;
#(
   parameter int unsigned CHUNK = 8,
   localparam int unsigned PW = cnt_w(CHUNK)
) (
   input  logic [CHUNK-1:0] data,
   output logic [PW-1:0]    count
);

   always_comb begin
      count = '0;
      for (int unsigned i = 0; i < CHUNK; i++) begin
         count = count + PW'(data[i]);
      end
   end

endmodule

// File: rtl/popcount_stream.sv
// Multi-cycle population counter for wide words, CHUNK bits per cycle, with
// valid/ready handshakes on both sides and an optional saturating running total.
// Ports:
//   clk, reset           : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready is high only in IDLE
//   in_data              : word to count
//   in_zeros             : 1 = count zeros, 0 = count ones (sampled at accept)
//   in_acc               : 1 = add result to running total (sampled at accept)
//   acc_clear            : synchronous clear of running total and sticky flag
//   out_valid / out_ready: output handshake; out_valid is high in DONE
//   out_count            : count of the accepted word, stable while out_valid
//   out_total            : saturating running total, always visible
//   out_sat              : sticky saturation flag
module popcount_stream
   import popcount_pkg::*;
#(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CHUNK = 8,
   parameter int unsigned ACC_W = 16,
   localparam int unsigned CW = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_zeros,
   input  logic             in_acc,
   input  logic             acc_clear,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic [ACC_W-1:0] out_total,
   output logic             out_sat
);

   localparam int unsigned N  = WIDTH / CHUNK;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned PW = cnt_w(CHUNK);

   localparam logic [KW-1:0]  K_LAST  = KW'(N - 1);
   localparam logic [ACC_W:0] TOT_MAX = {1'b0, {ACC_W{1'b1}}};

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   word_q, word_d;
   logic               acc_q, acc_d;
   logic [KW-1:0]      k_q, k_d;
   logic [CW-1:0]      partial_q, partial_d;
   logic [CW-1:0]      count_q, count_d;
   logic [ACC_W-1:0]   total_q, total_d;
   logic               sat_q, sat_d;

   logic [PW-1:0]      chunk_cnt;
   logic [CW-1:0]      sum_next;
   logic               acc_upd;
   logic [ACC_W-1:0]   total_base;
   logic               sat_base;
   logic [ACC_W:0]     total_sum;

   // The latched word is shifted down one chunk per cycle, so the chunk being
   // counted (word[k*CHUNK +: CHUNK]) always sits in the low bits.
   popcount_chunk #(
      .CHUNK (CHUNK)
   ) u_chunk (
      .data  (word_q[CHUNK-1:0]),
      .count (chunk_cnt)
   );

   assign sum_next = partial_q + CW'(chunk_cnt);

   // A clear in the same cycle as an accumulate acts first, so the add starts
   // from zero and the sticky flag only reflects this word.
   assign total_base = acc_clear ? '0 : total_q;
   assign sat_base   = acc_clear ? 1'b0 : sat_q;
   assign total_sum  = {1'b0, total_base} + (ACC_W + 1)'(sum_next);

   always_comb begin
      state_d   = state_q;
      word_d    = word_q;
      acc_d     = acc_q;
      k_d       = k_q;
      partial_d = partial_q;
      count_d   = count_q;
      acc_upd   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               word_d    = in_zeros ? ~in_data : in_data;
               acc_d     = in_acc;
               partial_d = '0;
               k_d       = '0;
               state_d   = COUNT;
            end
         end
         COUNT: begin
            partial_d = sum_next;
            k_d       = k_q + 1'b1;
            word_d    = word_q >> CHUNK;
            if (k_q == K_LAST) begin
               count_d = sum_next;
               acc_upd = acc_q;
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      total_d = total_q;
      sat_d   = sat_q;
      if (acc_upd) begin
         if (total_sum > TOT_MAX) begin
            total_d = {ACC_W{1'b1}};
            sat_d   = 1'b1;
         end else begin
            total_d = total_sum[ACC_W-1:0];
            sat_d   = sat_base;
         end
      end else if (acc_clear) begin
         total_d = '0;
         sat_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         word_q    <= '0;
         acc_q     <= 1'b0;
         k_q       <= '0;
         partial_q <= '0;
         count_q   <= '0;
         total_q   <= '0;
         sat_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         word_q    <= word_d;
         acc_q     <= acc_d;
         k_q       <= k_d;
         partial_q <= partial_d;
         count_q   <= count_d;
         total_q   <= total_d;
         sat_q     <= sat_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_count = count_q;
   assign out_total = total_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_popcount_stream.sv
// Self-checking bench for popcount_stream. Two instances (ACC_W=16 and ACC_W=6)
// share all inputs; each is checked against its own saturating total model.
module tb_popcount_stream;

   localparam int unsigned WIDTH = 32;
   localparam int unsigned CHUNK = 8;
   localparam int unsigned NCH   = WIDTH / CHUNK;
   localparam int unsigned CW    = 6;
   localparam int MAX_A = 65535;
   localparam int MAX_B = 63;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_zeros;
   logic             in_acc;
   logic             acc_clear;
   logic             out_ready;

   logic             in_ready_a, out_valid_a, out_sat_a;
   logic [CW-1:0]    out_count_a;
   logic [15:0]      out_total_a;
   logic             in_ready_b, out_valid_b, out_sat_b;
   logic [CW-1:0]    out_count_b;
   logic [5:0]       out_total_b;

   int checks = 0;
   int errors = 0;
   int tot_a, tot_b;
   bit sat_a, sat_b;

   popcount_stream #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(16)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_a),
      .in_data   (in_data),
      .in_zeros  (in_zeros),
      .in_acc    (in_acc),
      .acc_clear (acc_clear),
      .out_valid (out_valid_a),
      .out_ready (out_ready),
      .out_count (out_count_a),
      .out_total (out_total_a),
      .out_sat   (out_sat_a)
   );

   popcount_stream #(.WIDTH(WIDTH), .CHUNK(CHUNK), .ACC_W(6)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready_b),
      .in_data   (in_data),
      .in_zeros  (in_zeros),
      .in_acc    (in_acc),
      .acc_clear (acc_clear),
      .out_valid (out_valid_b),
      .out_ready (out_ready),
      .out_count (out_count_b),
      .out_total (out_total_b),
      .out_sat   (out_sat_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        zeros;
      int          stall;
      int          exp;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_clear();
      tot_a = 0;
      tot_b = 0;
      sat_a = 1'b0;
      sat_b = 1'b0;
   endtask

   task automatic model_add(input int cnt);
      if (tot_a + cnt > MAX_A) begin
         tot_a = MAX_A;
         sat_a = 1'b1;
      end else begin
         tot_a = tot_a + cnt;
      end
      if (tot_b + cnt > MAX_B) begin
         tot_b = MAX_B;
         sat_b = 1'b1;
      end else begin
         tot_b = tot_b + cnt;
      end
   endtask

   task automatic check_totals(input string tag);
      check({tag, " total_a"}, 32'(out_total_a), tot_a);
      check({tag, " total_b"}, 32'(out_total_b), tot_b);
      check({tag, " sat_a"}, 32'(out_sat_a), 32'(sat_a));
      check({tag, " sat_b"}, 32'(out_sat_b), 32'(sat_b));
   endtask

   // Offers one word, checks latency/count/totals, holds out_ready low for
   // `stall` cycles, then releases. While busy, in_valid stays high with junk
   // data and flipped control bits that must be ignored. clr_at > 0 asserts
   // acc_clear during the cycle before that COUNT edge (NCH = final edge).
   task automatic run_word(input string tag, input logic [31:0] d, input logic z,
                           input logic a, input int stall, input int clr_at, input int exp);
      int lat;
      int g;
      g = 0;
      while (!in_ready_a && g < 20) begin
         tick();
         g++;
      end
      check({tag, " in_ready idle"}, 32'(in_ready_a & in_ready_b), 1);
      in_valid  = 1'b1;
      in_data   = d;
      in_zeros  = z;
      in_acc    = a;
      out_ready = 1'b0;
      tick();
      in_data  = ~d ^ 32'h5A5A_0F0F;
      in_zeros = ~z;
      in_acc   = ~a;
      lat = 0;
      while (!out_valid_a && lat < 20) begin
         acc_clear = (lat + 1 == clr_at);
         tick();
         lat++;
      end
      acc_clear = 1'b0;
      check({tag, " latency"}, lat, NCH);
      check({tag, " out_valid_b"}, 32'(out_valid_b), 1);
      if (clr_at > 0) model_clear();
      if (a) model_add(exp);
      check({tag, " count_a"}, 32'(out_count_a), exp);
      check({tag, " count_b"}, 32'(out_count_b), exp);
      check_totals(tag);
      for (int i = 0; i < stall; i++) begin
         tick();
         check({tag, " stall count"}, 32'(out_count_a), exp);
         check({tag, " stall ready"}, 32'(in_ready_a | in_ready_b), 0);
         check({tag, " stall valid"}, 32'(out_valid_a), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, " ready after take"}, 32'(in_ready_a), 1);
      check({tag, " valid after take"}, 32'(out_valid_a), 0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      logic        z;
      logic        a;
      int          st;
      int          clr;
      int          exp;

      vecs[0] = '{32'hFFFF_FFFF, 1'b0, 0, 32};
      vecs[1] = '{32'h0000_0001, 1'b0, 0, 1};
      vecs[2] = '{32'hF0F0_0000, 1'b1, 5, 24};
      vecs[3] = '{32'h0000_0000, 1'b0, 0, 0};
      vecs[4] = '{32'h0000_0000, 1'b1, 1, 32};
      vecs[5] = '{32'h8000_0001, 1'b0, 0, 2};
      vecs[6] = '{32'hA5A5_A5A5, 1'b0, 2, 16};
      vecs[7] = '{32'h0000_FFFF, 1'b1, 0, 16};
      vecs[8] = '{32'h1234_5678, 1'b0, 0, 13};
      vecs[9] = '{32'hFF00_FF00, 1'b1, 3, 16};

      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_zeros  = 1'b0;
      in_acc    = 1'b0;
      acc_clear = 1'b0;
      out_ready = 1'b0;
      model_clear();
      tick();
      tick();
      reset = 1'b0;
      check("reset in_ready", 32'(in_ready_a & in_ready_b), 1);
      check("reset out_valid", 32'(out_valid_a | out_valid_b), 0);
      check("reset count", 32'(out_count_a), 0);
      check_totals("reset");

      for (int i = 0; i < 10; i++) begin
         run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].zeros, 1'b0,
                  vecs[i].stall, -1, vecs[i].exp);
      end

      // Saturation on the 6-bit total.
      for (int i = 0; i < 3; i++) begin
         run_word($sformatf("sat%0d", i), 32'hFFFF_FFFF, 1'b0, 1'b1, 0, -1, 32);
         check($sformatf("sat%0d total_b", i), 32'(out_total_b), (i == 0) ? 32 : 63);
         check($sformatf("sat%0d sat_b", i), 32'(out_sat_b), (i == 0) ? 0 : 1);
         check($sformatf("sat%0d total_a", i), 32'(out_total_a), 32 * (i + 1));
      end
      // Clear-then-add while saturated: flag follows this word only.
      run_word("clradd_sat", 32'h0000_007F, 1'b0, 1'b1, 0, NCH, 7);
      check("clradd_sat sat_b", 32'(out_sat_b), 0);
      acc_clear = 1'b1;
      tick();
      acc_clear = 1'b0;
      model_clear();
      check("clear total_b", 32'(out_total_b), 0);
      check("clear sat_b", 32'(out_sat_b), 0);
      check("clear total_a", 32'(out_total_a), 0);

      run_word("pre20", 32'h000F_FFFF, 1'b0, 1'b1, 0, -1, 20);
      check("pre20 total", 32'(out_total_a), 20);
      run_word("clradd7", 32'h0000_007F, 1'b0, 1'b1, 0, NCH, 7);
      check("clradd7 total_a", 32'(out_total_a), 7);
      check("clradd7 total_b", 32'(out_total_b), 7);

      // Reset in the middle of COUNT (k = 2).
      in_valid = 1'b1;
      in_data  = 32'hFFFF_FFFF;
      in_zeros = 1'b0;
      in_acc   = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("midrst busy", 32'(in_ready_a), 0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_clear();
      check("midrst in_ready", 32'(in_ready_a & in_ready_b), 1);
      check("midrst out_valid", 32'(out_valid_a | out_valid_b), 0);
      check("midrst count", 32'(out_count_a), 0);
      check_totals("midrst");
      tick();
      check("midrst stays idle", 32'(in_ready_a), 1);
      run_word("post_rst", 32'h0000_00FF, 1'b0, 1'b0, 0, -1, 8);

      // Random regression against $countones and saturating models.
      for (int i = 0; i < 200; i++) begin
         d   = $urandom;
         z   = 1'($urandom_range(0, 1));
         a   = 1'($urandom_range(0, 1));
         st  = $urandom_range(0, 3);
         clr = ($urandom_range(0, 7) == 0) ? $urandom_range(1, NCH) : -1;
         exp = z ? $countones(~d) : $countones(d);
         run_word($sformatf("rnd%0d", i), d, z, a, st, clr, exp);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
